// File: rtl/fir_requant_fifo.sv
// Requantises the full-precision FIR sum back to the Q(n).(m) sample format
// with half-up rounding and saturation, then buffers the results in a valid/ready FIFO.
module fir_requant_fifo #(
  parameter int m     = 7,
  parameter int n     = 3,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2*m+2*n-1:0]       y,
  output logic [m+n-1:0]           out_data,
  output logic                     out_sat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int YW = 2*m + 2*n;
  localparam int DW = m + n;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [YW:0] HALF = (YW+1)'(1) << (m-1);

  logic [YW:0]    w_r;
  logic [YW:0]    w_q;
  logic           w_sat;
  logic [DW-1:0]  w_qdata;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;

  logic [DW-1:0]  r_stg_data;
  logic           r_stg_sat;
  logic           r_stg_vld;
  logic [DW:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [CW-1:0]  r_cnt;
  logic           r_ovf;

  // One extra bit on the sum so the rounding add cannot wrap.
  assign w_r     = {1'b0, y} + HALF;
  assign w_q     = w_r >> m;
  assign w_sat   = |w_q[YW:DW];
  assign w_qdata = w_sat ? {DW{1'b1}} : w_q[DW-1:0];

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = (r_cnt != '0) && out_ready;
  assign w_push  = r_stg_vld && (!w_full || w_pop);
  assign w_drop  = r_stg_vld && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stg_data <= '0;
      r_stg_sat  <= 1'b0;
      r_stg_vld  <= 1'b0;
    end else begin
      r_stg_vld <= en;
      if (en) begin
        r_stg_data <= w_qdata;
        r_stg_sat  <= w_sat;
      end
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {r_stg_sat, r_stg_data};
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign {out_sat, out_data} = r_mem[r_rd];
  assign out_valid = (r_cnt != '0);
  assign count     = r_cnt;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fir_requant_fifo.sv
// Directed bench for fir_requant_fifo: rounding, saturation, back-pressure,
// full-FIFO push/pop with pointer wrap and mid-stream reset.
module tb_fir_requant_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [19:0] y;
  logic [9:0]  out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        ovf;
  logic        ovf_clr;

  int checks = 0;
  int errors = 0;

  fir_requant_fifo #(.m(7), .n(3), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .y         (y),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [9:0] d, input logic s);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_sat"},   32'(out_sat),   32'(s));
  endtask

  logic [19:0] rnd_y [3]  = '{20'h0033F, 20'h003BF, 20'h003C0};
  logic [9:0]  rnd_d [3]  = '{10'h006, 10'h007, 10'h008};
  logic [19:0] sat_y [3]  = '{20'h1FFBF, 20'h1FFC0, 20'hFFFFF};
  logic        sat_s [3]  = '{1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; en = 1'b0; y = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_sat",   32'(out_sat),   32'd0);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);

    // Single sample: two-edge latency, then popped.
    en = 1'b1; y = 20'h00380; out_ready = 1'b1;
    step();
    en = 1'b0;
    chk("lat_k_valid", 32'(out_valid), 32'd0);
    step();
    chk_head("lat_head", 10'h007, 1'b0);
    chk("lat_count1", 32'(count), 32'd1);
    step();
    chk("lat_count0", 32'(count), 32'd0);
    chk("lat_valid0", 32'(out_valid), 32'd0);

    // Rounding sequence held under back-pressure, then drained.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; y = rnd_y[i];
      step();
    end
    en = 1'b0;
    step();
    chk("rnd_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_head($sformatf("rnd%0d", i), rnd_d[i], 1'b0);
      step();
    end
    chk("rnd_empty", 32'(out_valid), 32'd0);

    // Saturation boundary.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; y = sat_y[i];
      step();
    end
    en = 1'b0;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_head($sformatf("sat%0d", i), 10'h3FF, sat_s[i]);
      step();
    end

    // Back-pressure: 10 samples, last two dropped.
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      en = 1'b1; y = 20'(i) << 7;
      step();
    end
    en = 1'b0;
    step();
    chk("bp_count", 32'(count), 32'd8);
    chk("bp_ovf",   32'(ovf),   32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk_head($sformatf("bp%0d", i), 10'(i), 1'b0);
      step();
    end
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("bp_ovf_clr", 32'(ovf), 32'd0);

    // Full FIFO with simultaneous push and pop across pointer wrap.
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      en = 1'b1; y = 20'(20 + i) << 7;
      step();
    end
    chk("full_count", 32'(count), 32'd8);
    out_ready = 1'b1;
    for (int j = 10; j <= 14; j++) begin
      en = 1'b1; y = 20'(20 + j) << 7;
      chk_head($sformatf("pp%0d", j), 10'(20 + j - 9), 1'b0);
      step();
      chk($sformatf("pp%0d_count", j), 32'(count), 32'd8);
      chk($sformatf("pp%0d_ovf", j),   32'(ovf),   32'd0);
    end
    en = 1'b0;
    for (int k = 6; k <= 14; k++) begin
      chk_head($sformatf("drain%0d", k), 10'(20 + k), 1'b0);
      step();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Mid-stream reset with entries queued and en high.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      en = 1'b1; y = 20'(40 + i) << 7;
      step();
    end
    chk("mr_count4", 32'(count), 32'd4);
    rst = 1'b1; en = 1'b1;
    step();
    rst = 1'b0; en = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_count", 32'(count),     32'd0);
    chk("mr_ovf",   32'(ovf),       32'd0);
    chk("mr_data",  32'(out_data),  32'd0);
    step();
    chk("mr_nostale", 32'(count), 32'd0);
    en = 1'b1; y = 20'h00380;
    step();
    en = 1'b0;
    chk("mr_k_valid", 32'(out_valid), 32'd0);
    step();
    chk_head("mr_first", 10'h007, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
